load_align_unit: RTL and testbench
==================================

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width (32 or 64); NBYTES = XLEN/8.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock, sole clock.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req_valid in 1, req_ready out 1, req_funct3 in 3, req_addr in XLEN  load request channel; funct3 uses the RV encoding (LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110).
REQ-005 SHALL have ports: mem_req_valid out 1, mem_req_ready in 1, mem_addr out XLEN  aligned memory read request.
REQ-006 SHALL have ports: mem_rvalid in 1, mem_rdata in XLEN  memory read return, variable latency of 1 or more cycles, in order.
REQ-007 SHALL have ports: rsp_valid out 1, rsp_ready in 1, rsp_data out XLEN, rsp_misalign out 1, rsp_illegal out 1  response channel.

Function
REQ-008 SHALL implement FSM states IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP; req_ready = 1 only in IDLE.
REQ-009 SHALL, on req_valid&&req_ready, latch funct3 and addr; offset = addr mod NBYTES; size = 1<<funct3[1:0] bytes; unsigned = funct3[2].
REQ-010 SHALL flag illegal when funct3 = 111, or when XLEN = 32 and funct3 is 011 or 110; go IDLE->RESP with rsp_data 0, rsp_illegal 1, no memory access.
REQ-011 SHALL, in REQ0, drive mem_req_valid 1, mem_addr = addr with low log2(NBYTES) bits cleared; advance to WAIT0 on mem_req_ready.
REQ-012 SHALL capture mem_rdata in WAIT0 on mem_rvalid as beat0; -> REQ1 if the access crosses (offset+size > NBYTES), else -> RESP.
REQ-013 SHALL, in REQ1/WAIT1, request aligned addr + NBYTES (modulo 2^XLEN, wrap permitted) and capture beat1.
REQ-014 SHALL form raw = ({beat1,beat0} >> 8*offset) truncated to size bytes; beat1 = 0 when not crossing.
REQ-015 SHALL zero-extend raw to XLEN when unsigned or size = XLEN, else sign-extend from bit 8*size-1.
REQ-016 SHALL register rsp_data/rsp_misalign/rsp_illegal on entry to RESP; hold them and rsp_valid stable until rsp_ready; rsp_valid&&rsp_ready -> IDLE.
REQ-017 SHALL NOT accept a new request in the same cycle as a response handshake (one cycle back in IDLE minimum).
REQ-018 SHALL give latency, aligned load, 1-cycle memory, mem_req_ready high: accept at T, mem_req_valid at T+1, rvalid at T+2, rsp_valid at T+3.
REQ-019 SHALL ignore mem_rvalid in IDLE, REQ0, REQ1 and RESP.

Reset
REQ-020 SHALL, while rst is high at a clock edge, force state IDLE and all registered outputs (rsp_valid, rsp_data, rsp_misalign, rsp_illegal, mem_req_valid, mem_addr) to 0; req_ready = 0 while rst is high.
REQ-021 SHALL abandon any in-flight load on reset mid-operation; returns arriving afterwards fall under REQ-019.

Configuration
REQ-022 SHALL support macro MISALIGN_SPLIT_EN: when defined, misaligned loads are legal; non-crossing uses one beat, crossing uses two beats per REQ-012..014.
REQ-023 SHALL, when MISALIGN_SPLIT_EN is undefined, treat any load with offset mod size != 0 as misaligned: no memory access, IDLE->RESP, rsp_data 0, rsp_misalign 1; REQ1/WAIT1 unreachable.

Verification (XLEN=32)
REQ-024 SHALL cover: LB addr 0x1003, word@0x1000 = 0x80123456 -> mem_addr 0x1000, rsp_data 0xFFFFFF80, both flags 0.
REQ-025 SHALL cover: LHU addr 0x1002, word 0xBEEF1234 -> rsp_data 0x0000BEEF; LH, same inputs -> 0xFFFFBEEF.
REQ-026 SHALL cover: LW addr 0x1001, words 0x44332211@0x1000, 0x88776655@0x1004 -> with macro: requests 0x1000 then 0x1004, rsp_data 0x55443322; without macro: no mem_req_valid, rsp_misalign 1, rsp_data 0.
REQ-027 SHALL cover: funct3 011 or 111 -> rsp_illegal 1, rsp_data 0, no memory request.
REQ-028 SHALL cover: rsp_ready low 3 cycles -> rsp_data stable, req_ready 0; request offered during the handshake cycle accepted one cycle later.
REQ-029 SHALL cover: rst pulsed in WAIT1 -> next cycle IDLE with outputs 0; late mem_rvalid 0xDEADBEEF ignored, and the next LW at 0x2000 returns the correct data.

Source files
------------

// File: rtl/load_align_unit.sv
// load_align_unit: RISC-V style load alignment unit.
// Turns a byte-addressed load (LB/LH/LW/LD/LBU/LHU/LWU) into one or two aligned
// memory reads, then shifts, truncates and sign/zero-extends the returned data.
// Optional feature macro: MISALIGN_SPLIT_EN. When defined, misaligned loads are
// serviced (two beats when the access crosses a word boundary). When undefined,
// any misaligned load is answered immediately with rsp_misalign and no memory access.
module load_align_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_misalign,
    output logic            rsp_illegal
);

    localparam int unsigned NBYTES = XLEN / 8;
    localparam int unsigned OFFW   = $clog2(NBYTES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_e;

    state_e state_q, state_d;

    // Latched request and first returned beat
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] beat0_q;

    // Registered outputs and their next values
    logic            mem_req_valid_q, mem_req_valid_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_misalign_q, rsp_misalign_d;
    logic            rsp_illegal_q, rsp_illegal_d;

    // Decode helpers
    logic            req_illegal_c;
    logic            req_misalign_c;
    logic            crossing_c;
    logic [OFFW-1:0] off_q;
    logic [XLEN-1:0] req_base_c;
    logic [XLEN-1:0] addr_base_c;

    // Shift the beat pair down by the byte offset, keep size bytes, then extend
    function automatic logic [XLEN-1:0] align_load(
        input logic [XLEN-1:0] b1,
        input logic [XLEN-1:0] b0,
        input logic [OFFW-1:0] off,
        input logic [2:0]      f3
    );
        logic [XLEN-1:0] low;
        logic [XLEN-1:0] mask;
        logic            sbit;
        logic            sext;
        int unsigned     nbits;
        low   = XLEN'({b1, b0} >> {off, 3'b000});
        nbits = 32'd8 << f3[1:0];
        case (f3[1:0])
            2'd0:    sbit = low[7];
            2'd1:    sbit = low[15];
            2'd2:    sbit = low[31];
            default: sbit = low[XLEN-1];
        endcase
        sext = !f3[2] && (nbits < XLEN);
        mask = (nbits >= XLEN) ? {XLEN{1'b1}} : ((XLEN'(1) << nbits) - XLEN'(1));
        return (low & mask) | (~mask & {XLEN{sext & sbit}});
    endfunction

    // Illegal encodings: 111 always, LD/LWU only exist on a 64-bit datapath
    assign req_illegal_c = (req_funct3 == 3'b111) ||
                           ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));

    assign off_q       = addr_q[OFFW-1:0];
    assign req_base_c  = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign addr_base_c = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};

`ifdef MISALIGN_SPLIT_EN
    // Misaligned loads are legal; a second beat is needed when the bytes spill over
    assign req_misalign_c = 1'b0;
    assign crossing_c     = (32'(off_q) + (32'd1 << funct3_q[1:0])) > NBYTES;
`else
    // Offset must be a multiple of the access size; nothing ever crosses a word
    assign req_misalign_c = (32'(req_addr[OFFW-1:0]) &
                             ((32'd1 << req_funct3[1:0]) - 32'd1)) != 32'd0;
    assign crossing_c     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = (req_illegal_c || req_misalign_c) ? RESP : REQ0;
                end
            end
            REQ0: begin
                if (mem_req_ready) state_d = WAIT0;
            end
            WAIT0: begin
                if (mem_rvalid) state_d = crossing_c ? REQ1 : RESP;
            end
            REQ1: begin
                if (mem_req_ready) state_d = WAIT1;
            end
            WAIT1: begin
                if (mem_rvalid) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next values: memory request follows the next state, response is built on entry to RESP
    always_comb begin
        mem_req_valid_d = 1'b0;
        mem_addr_d      = mem_addr_q;
        rsp_valid_d     = (state_d == RESP);
        rsp_data_d      = rsp_data_q;
        rsp_misalign_d  = rsp_misalign_q;
        rsp_illegal_d   = rsp_illegal_q;

        if (state_d == REQ0) begin
            mem_req_valid_d = 1'b1;
            mem_addr_d      = (state_q == IDLE) ? req_base_c : addr_base_c;
        end
        if (state_d == REQ1) begin
            mem_req_valid_d = 1'b1;
            mem_addr_d      = addr_base_c + XLEN'(NBYTES);
        end

        if ((state_d == RESP) && (state_q != RESP)) begin
            case (state_q)
                IDLE: begin
                    rsp_data_d     = '0;
                    rsp_illegal_d  = req_illegal_c;
                    rsp_misalign_d = !req_illegal_c;
                end
                WAIT0: begin
                    rsp_data_d     = align_load('0, mem_rdata, off_q, funct3_q);
                    rsp_illegal_d  = 1'b0;
                    rsp_misalign_d = 1'b0;
                end
                WAIT1: begin
                    rsp_data_d     = align_load(mem_rdata, beat0_q, off_q, funct3_q);
                    rsp_illegal_d  = 1'b0;
                    rsp_misalign_d = 1'b0;
                end
                default: begin
                    rsp_data_d = rsp_data_q;
                end
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_misalign_q  <= 1'b0;
            rsp_illegal_q   <= 1'b0;
        end else begin
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_misalign_q  <= rsp_misalign_d;
            rsp_illegal_q   <= rsp_illegal_d;
        end
    end

    // Request latch and first-beat capture
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q <= '0;
            addr_q   <= '0;
            beat0_q  <= '0;
        end else begin
            if ((state_q == IDLE) && req_valid) begin
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
            end
            if ((state_q == WAIT0) && mem_rvalid) begin
                beat0_q <= mem_rdata;
            end
        end
    end

    assign req_ready     = (state_q == IDLE) && !rst;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_misalign  = rsp_misalign_q;
    assign rsp_illegal   = rsp_illegal_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit (XLEN=32): directed vector table, hand-written
// latency / back-pressure / reset sequences, then random loads against a
// byte-level memory model.
module tb_load_align_unit;

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_misalign;
    logic        rsp_illegal;

    load_align_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr     (mem_addr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_misalign (rsp_misalign),
        .rsp_illegal  (rsp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Memory model state
    logic [31:0] mem_ovr [logic [31:0]];
    logic [31:0] req_log [$];
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          rdy_pct  = 100;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] exp_data;
        logic        exp_mis;
        logic        exp_ill;
        int          exp_nreq;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = word_at({a[31:2], 2'b00});
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    // Reference: gather bytes little-endian, extend arithmetically
    task automatic model(input logic [2:0] f3, input logic [31:0] a,
                         output logic [31:0] d, output logic mis, output logic ill, output int nreq);
        int unsigned     size;
        longint unsigned v;
        size = 32'd1 << f3[1:0];
        ill  = (f3 == 3'b111) || (f3 == 3'b011) || (f3 == 3'b110);
        mis  = 1'b0;
        d    = 32'h0;
        nreq = 0;
        if (ill) return;
        if (!SPLIT && ((a % size) != 0)) begin
            mis = 1'b1;
            return;
        end
        v = 0;
        for (int unsigned i = 0; i < size; i++) begin
            v = v | (64'(byte_at(a + 32'(i))) << (8 * i));
        end
        if (!f3[2] && (size < 4) && (v >= (64'd1 << (8 * size - 1)))) begin
            v = v + 64'h1_0000_0000 - (64'd1 << (8 * size));
        end
        d    = v[31:0];
        nreq = (((a % 4) + size) > 4) ? 2 : 1;
    endtask

    // One clock: move to the falling edge, then play the memory side
    task automatic cyc();
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = word_at(pend_addr);
            end
        end
        mem_req_ready = ($urandom_range(99) < rdy_pct);
        if (mem_req_valid && mem_req_ready) begin
            req_log.push_back(mem_addr);
            pend_addr = mem_addr;
            pend_cnt  = $urandom_range(lat_max, lat_min);
        end
    endtask

    task automatic wait_rsp(output bit to);
        int n;
        n  = 0;
        to = 1'b0;
        while (!rsp_valid && n < 200) begin
            cyc();
            n++;
        end
        if (!rsp_valid) to = 1'b1;
    endtask

    // Issue one load, hold rsp_ready low for 'stall' cycles, then complete the handshake
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a, input int stall,
                            output logic [31:0] d, output logic mis, output logic ill, output bit to);
        int n;
        n = 0;
        req_log.delete();
        while (!req_ready && n < 100) begin
            cyc();
            n++;
        end
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_addr   = a;
        cyc();
        req_valid = 1'b0;
        req_addr  = $urandom;
        wait_rsp(to);
        d   = rsp_data;
        mis = rsp_misalign;
        ill = rsp_illegal;
        if (to) return;
        for (int s = 0; s < stall; s++) begin
            rsp_ready = 1'b0;
            cyc();
            chk({tag, ".hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, ".hold_data"}, 64'(rsp_data), 64'(d));
            chk({tag, ".hold_ready"}, 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [2:0] f3, input logic [31:0] a, input int stall,
                             input logic [31:0] ed, input logic em, input logic ei, input int en);
        logic [31:0] d;
        logic        mis;
        logic        ill;
        bit          to;
        logic [31:0] base;
        logic [31:0] a0;
        logic [31:0] a1;
        run_load(tag, f3, a, stall, d, mis, ill, to);
        chk({tag, ".timeout"}, 64'(to), 64'd0);
        if (to) return;
        base = {a[31:2], 2'b00};
        a0   = (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx;
        a1   = (req_log.size() > 1) ? req_log[1] : 32'hxxxx_xxxx;
        chk({tag, ".data"}, 64'(d), 64'(ed));
        chk({tag, ".misalign"}, 64'(mis), 64'(em));
        chk({tag, ".illegal"}, 64'(ill), 64'(ei));
        chk({tag, ".nreq"}, 64'(req_log.size()), 64'(en));
        if (en > 0) chk({tag, ".addr0"}, 64'(a0), 64'(base));
        if (en > 1) chk({tag, ".addr1"}, 64'(a1), 64'(base + 32'd4));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] ed;
        logic        em;
        logic        ei;
        int          en;
        logic [2:0]  f3;
        logic [31:0] a;
        bit          to;
        int          n;

        vecs[0]  = '{3'b000, 32'h0000_1003, 32'h8012_3456, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0, 1};
        vecs[1]  = '{3'b101, 32'h0000_1002, 32'hBEEF_1234, 32'h0, 32'h0000_BEEF, 1'b0, 1'b0, 1};
        vecs[2]  = '{3'b001, 32'h0000_1002, 32'hBEEF_1234, 32'h0, 32'hFFFF_BEEF, 1'b0, 1'b0, 1};
        vecs[3]  = '{3'b010, 32'h0000_1001, 32'h4433_2211, 32'h8877_6655,
                     SPLIT ? 32'h5544_3322 : 32'h0, !SPLIT, 1'b0, SPLIT ? 2 : 0};
        vecs[4]  = '{3'b011, 32'h0000_1000, 32'h4433_2211, 32'h0, 32'h0, 1'b0, 1'b1, 0};
        vecs[5]  = '{3'b111, 32'h0000_1000, 32'h4433_2211, 32'h0, 32'h0, 1'b0, 1'b1, 0};
        vecs[6]  = '{3'b110, 32'h0000_1000, 32'h4433_2211, 32'h0, 32'h0, 1'b0, 1'b1, 0};
        vecs[7]  = '{3'b010, 32'h0000_1000, 32'h4433_2211, 32'h0, 32'h4433_2211, 1'b0, 1'b0, 1};
        vecs[8]  = '{3'b100, 32'h0000_1003, 32'h8012_3456, 32'h0, 32'h0000_0080, 1'b0, 1'b0, 1};
        vecs[9]  = '{3'b001, 32'h0000_1001, 32'h4433_2211, 32'h0,
                     SPLIT ? 32'h0000_3322 : 32'h0, !SPLIT, 1'b0, SPLIT ? 1 : 0};
        vecs[10] = '{3'b001, 32'h0000_1003, 32'h4433_2211, 32'h8877_6655,
                     SPLIT ? 32'h0000_5544 : 32'h0, !SPLIT, 1'b0, SPLIT ? 2 : 0};
        vecs[11] = '{3'b010, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 32'h0F0E_0D0C,
                     SPLIT ? 32'h0D0C_A1B2 : 32'h0, !SPLIT, 1'b0, SPLIT ? 2 : 0};
        vecs[12] = '{3'b001, 32'h0000_1006, 32'hF00D_CAFE, 32'h0, 32'hFFFF_F00D, 1'b0, 1'b0, 1};
        vecs[13] = '{3'b111, 32'h0000_1003, 32'h4433_2211, 32'h0, 32'h0, 1'b0, 1'b1, 0};

        rst           = 1'b1;
        req_valid     = 1'b0;
        req_funct3    = 3'b000;
        req_addr      = 32'h0;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 32'h0;
        rsp_ready     = 1'b0;

        // Reset state
        cyc();
        cyc();
        chk("rst.req_ready", 64'(req_ready), 64'd0);
        chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst.mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst.mem_addr", 64'(mem_addr), 64'd0);
        chk("rst.rsp_data", 64'(rsp_data), 64'd0);
        chk("rst.flags", 64'({rsp_misalign, rsp_illegal}), 64'd0);
        rst = 1'b0;
        cyc();
        chk("idle.req_ready", 64'(req_ready), 64'd1);

        // Latency of an aligned load with a 1-cycle memory
        mem_ovr[32'h1000] = 32'h4433_2211;
        lat_min = 1; lat_max = 1; rdy_pct = 100;
        req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h1000;
        cyc();
        req_valid = 1'b0;
        chk("lat.mem_req_valid_T1", 64'(mem_req_valid), 64'd1);
        chk("lat.mem_addr_T1", 64'(mem_addr), 64'h1000);
        chk("lat.req_ready_busy", 64'(req_ready), 64'd0);
        cyc();
        chk("lat.mem_req_valid_T2", 64'(mem_req_valid), 64'd0);
        chk("lat.rsp_valid_T2", 64'(rsp_valid), 64'd0);
        cyc();
        chk("lat.rsp_valid_T3", 64'(rsp_valid), 64'd1);
        chk("lat.rsp_data_T3", 64'(rsp_data), 64'h4433_2211);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;

        // Directed vector table
        lat_min = 1; lat_max = 3; rdy_pct = 70;
        for (int i = 0; i < 14; i++) begin
            mem_ovr[{vecs[i].addr[31:2], 2'b00}]          = vecs[i].w0;
            mem_ovr[{vecs[i].addr[31:2], 2'b00} + 32'd4] = vecs[i].w1;
            run_check($sformatf("vec%0d", i), vecs[i].f3, vecs[i].addr, i % 3,
                      vecs[i].exp_data, vecs[i].exp_mis, vecs[i].exp_ill, vecs[i].exp_nreq);
        end

        // Back-pressure: response held for 3 cycles, new request offered in the handshake cycle
        lat_min = 1; lat_max = 1; rdy_pct = 100;
        mem_ovr[32'h1000] = 32'h8012_3456;
        req_valid = 1'b1; req_funct3 = 3'b000; req_addr = 32'h1003;
        cyc();
        req_valid = 1'b0;
        wait_rsp(to);
        chk("bp.timeout", 64'(to), 64'd0);
        d = rsp_data;
        chk("bp.data", 64'(d), 64'hFFFF_FF80);
        for (int s = 0; s < 3; s++) begin
            rsp_ready = 1'b0;
            cyc();
            chk("bp.hold_data", 64'(rsp_data), 64'(d));
            chk("bp.hold_valid", 64'(rsp_valid), 64'd1);
            chk("bp.req_ready_low", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h1000;
        cyc();
        rsp_ready = 1'b0;
        chk("bp.rsp_valid_dropped", 64'(rsp_valid), 64'd0);
        chk("bp.req_ready_back", 64'(req_ready), 64'd1);
        chk("bp.not_accepted_in_handshake", 64'(mem_req_valid), 64'd0);
        cyc();
        req_valid = 1'b0;
        chk("bp.accepted_next", 64'(mem_req_valid), 64'd1);
        chk("bp.mem_addr", 64'(mem_addr), 64'h1000);
        wait_rsp(to);
        chk("bp.timeout2", 64'(to), 64'd0);
        chk("bp.data2", 64'(rsp_data), 64'h8012_3456);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;

        // Reset while waiting for a memory return, then a late return must be ignored
        lat_min = 6; lat_max = 6; rdy_pct = 100;
        mem_ovr[32'h1000] = 32'h4433_2211;
        mem_ovr[32'h1004] = 32'h8877_6655;
        req_log.delete();
        req_valid = 1'b1;
        req_funct3 = 3'b010;
        req_addr = SPLIT ? 32'h1001 : 32'h1000;
        cyc();
        req_valid = 1'b0;
        n = 0;
        while ((req_log.size() < (SPLIT ? 2 : 1)) && n < 100) begin
            cyc();
            n++;
        end
        chk("rstmid.reached_wait", 64'(req_log.size()), SPLIT ? 64'd2 : 64'd1);
        cyc();
        rst = 1'b1;
        cyc();
        chk("rstmid.req_ready_in_rst", 64'(req_ready), 64'd0);
        chk("rstmid.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstmid.mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rstmid.mem_addr", 64'(mem_addr), 64'd0);
        chk("rstmid.rsp_data", 64'(rsp_data), 64'd0);
        rst        = 1'b0;
        pend_cnt   = 0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        cyc();
        chk("late.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("late.mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("late.req_ready", 64'(req_ready), 64'd1);
        lat_min = 1; lat_max = 2;
        mem_ovr[32'h2000] = 32'h1357_2468;
        run_check("after_rst", 3'b010, 32'h2000, 0, 32'h1357_2468, 1'b0, 1'b0, 1);

        // Random loads against the reference model
        lat_min = 1; lat_max = 4; rdy_pct = 60;
        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom_range(7));
            if ($urandom_range(7) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(7));
            else                        a = 32'h3000 + 32'($urandom_range(255));
            model(f3, a, ed, em, ei, en);
            run_check($sformatf("rnd%0d", i), f3, a, $urandom_range(2), ed, em, ei, en);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
